// File: rtl/tiro_nave.sv
// Player-ship shot controller: launches on a fire edge, climbs one STEP per
// movement tick, reports enemy hits and parks the sprite off-screen when idle.
module tiro_nave #(
  parameter int TICK_DIV = 50000,
  parameter int STEP     = 2,
  parameter int COOLDOWN = 20,
  parameter int NAVE_W   = 45,
  parameter int NAVE_H   = 51,
  parameter int INIM_W   = 40,
  parameter int INIM_H   = 32
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic       disparo,
  input  logic [9:0] x_nave,
  input  logic [9:0] y_nave,
  input  logic [9:0] x_inimigo,
  input  logic [9:0] y_inimigo,
  input  logic       inimigo_vivo,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       ativo,
  output logic       acertou,
  output logic [7:0] pontos
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int KW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [9:0] PARK = 10'd1000;

  typedef enum logic [1:0] {PRONTO, VOO, RECARGA} estado_t;

  estado_t       estado_reg;
  logic [CW-1:0] tick_cnt_reg;
  logic [KW-1:0] cooldown_reg;
  logic          disparo_q_reg;
  logic [9:0]    x_reg, y_reg;
  logic          ativo_reg, acertou_reg;
  logic [7:0]    pontos_reg;

  logic tick, fire, hit, top_exit;
  logic [10:0] x_ext, y_ext, xi_lo, xi_hi, yi_lo, yi_hi;

  assign tick = ~pausa && (tick_cnt_reg == CW'(TICK_DIV - 1));
  assign fire = disparo & ~disparo_q_reg;

  // Bounding-box sums are one bit wider so an enemy near 1023 cannot wrap.
  assign x_ext = {1'b0, x_reg};
  assign y_ext = {1'b0, y_reg};
  assign xi_lo = {1'b0, x_inimigo};
  assign yi_lo = {1'b0, y_inimigo};
  assign xi_hi = xi_lo + 11'(INIM_W);
  assign yi_hi = yi_lo + 11'(INIM_H);
  assign hit   = inimigo_vivo && (x_ext >= xi_lo) && (x_ext <= xi_hi)
                 && (y_ext >= yi_lo) && (y_ext <= yi_hi);
  assign top_exit = (y_reg < 10'(STEP));

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      estado_reg    <= PRONTO;
      tick_cnt_reg  <= '0;
      cooldown_reg  <= '0;
      disparo_q_reg <= 1'b0;
      x_reg         <= PARK;
      y_reg         <= PARK;
      ativo_reg     <= 1'b0;
      acertou_reg   <= 1'b0;
      pontos_reg    <= '0;
    end else if (reiniciarJogo) begin
      estado_reg    <= PRONTO;
      tick_cnt_reg  <= '0;
      cooldown_reg  <= '0;
      disparo_q_reg <= 1'b0;
      x_reg         <= PARK;
      y_reg         <= PARK;
      ativo_reg     <= 1'b0;
      acertou_reg   <= 1'b0;
      pontos_reg    <= '0;
    end else begin
      disparo_q_reg <= disparo;
      acertou_reg   <= 1'b0;
      if (!pausa) begin
        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
        case (estado_reg)
          PRONTO: begin
            // A ship at the very top has no room above it to spawn a shot.
            if (fire && (y_nave != 10'd0)) begin
              x_reg      <= x_nave + 10'(NAVE_W / 2);
              y_reg      <= y_nave - 10'd1;
              ativo_reg  <= 1'b1;
              estado_reg <= VOO;
            end
          end
          VOO: begin
            if (tick) begin
              if (hit || top_exit) begin
                x_reg        <= PARK;
                y_reg        <= PARK;
                ativo_reg    <= 1'b0;
                cooldown_reg <= KW'(COOLDOWN);
                estado_reg   <= RECARGA;
                if (hit) begin
                  acertou_reg <= 1'b1;
                  if (pontos_reg != 8'hFF)
                    pontos_reg <= pontos_reg + 8'd1;
                end
              end else begin
                y_reg <= y_reg - 10'(STEP);
              end
            end
          end
          RECARGA: begin
            if (tick) begin
              cooldown_reg <= cooldown_reg - 1'b1;
              if (cooldown_reg <= KW'(1))
                estado_reg <= PRONTO;
            end
          end
          default: estado_reg <= PRONTO;
        endcase
      end
    end
  end

  assign x       = x_reg;
  assign y       = y_reg;
  assign ativo   = ativo_reg;
  assign acertou = acertou_reg;
  assign pontos  = pontos_reg;

endmodule

// File: tb/tb_tiro_nave.sv
// Directed bench for tiro_nave with TICK_DIV=4; tracks the tick phase itself.
module tb_tiro_nave;

  logic       clk = 1'b0;
  logic       reset, pausa, reiniciarJogo, disparo, inimigo_vivo;
  logic [9:0] x_nave, y_nave, x_inimigo, y_inimigo;
  logic [9:0] x, y;
  logic       ativo, acertou;
  logic [7:0] pontos;

  int checks = 0;
  int failures = 0;
  int ph = 0;  // expected tick counter value after the latest edge

  tiro_nave #(.TICK_DIV(4), .STEP(2), .COOLDOWN(20)) dut (
    .CLOCK_50(clk), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .disparo(disparo), .x_nave(x_nave), .y_nave(y_nave),
    .x_inimigo(x_inimigo), .y_inimigo(y_inimigo), .inimigo_vivo(inimigo_vivo),
    .x(x), .y(y), .ativo(ativo), .acertou(acertou), .pontos(pontos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    if (!reset || reiniciarJogo) ph = 0;
    else if (!pausa) ph = (ph + 1) % 4;
  endtask

  task automatic to_tick();
    int n;
    n = 4 - ph;
    repeat (n) clk1();
  endtask

  task automatic restart();
    disparo = 1'b0;
    reiniciarJogo = 1'b1;
    clk1();
    reiniciarJogo = 1'b0;
  endtask

  task automatic fire();
    disparo = 1'b1;
    clk1();
    disparo = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pausa = 1'b0; reiniciarJogo = 1'b0; disparo = 1'b0;
    inimigo_vivo = 1'b0; x_nave = 10'd300; y_nave = 10'd400;
    x_inimigo = 10'd600; y_inimigo = 10'd600;
    repeat (2) clk1();
    chk("rst_x", x, 1000); chk("rst_y", y, 1000);
    chk("rst_ativo", ativo, 0); chk("rst_pontos", pontos, 0); chk("rst_acertou", acertou, 0);
    reset = 1'b1;

    // launch and climb
    disparo = 1'b1;
    clk1();
    chk("launch_x", x, 322); chk("launch_y", y, 399); chk("launch_ativo", ativo, 1);
    to_tick();
    chk("move1_y", y, 397);
    to_tick(); to_tick();
    chk("move3_y", y, 393); chk("move3_x", x, 322);

    // asynchronous reset mid-flight
    reset = 1'b0;
    #1;
    chk("arst_x", x, 1000); chk("arst_y", y, 1000);
    chk("arst_ativo", ativo, 0); chk("arst_pontos", pontos, 0);
    disparo = 1'b0;
    repeat (2) clk1();
    reset = 1'b1;
    repeat (6) clk1();
    chk("parked_ativo", ativo, 0); chk("parked_y", y, 1000);

    // hit on first tick, disparo held high
    x_inimigo = 10'd310; y_inimigo = 10'd380; inimigo_vivo = 1'b1;
    disparo = 1'b1;
    clk1();
    chk("hit_launch_y", y, 399);
    to_tick();
    chk("hit_acertou", acertou, 1); chk("hit_pontos", pontos, 1);
    chk("hit_park_x", x, 1000); chk("hit_park_y", y, 1000); chk("hit_ativo", ativo, 0);
    clk1();
    chk("hit_pulse_end", acertou, 0);
    for (int i = 2; i <= 20; i++) begin
      to_tick();
      if (i == 10) begin
        disparo = 1'b0; clk1(); disparo = 1'b1; clk1();
        chk("recarga_ignore", ativo, 0);
      end
    end
    repeat (3) clk1();
    chk("held_no_refire", ativo, 0);

    // pass-through with enemy dead
    inimigo_vivo = 1'b0;
    disparo = 1'b0; clk1();
    fire();
    chk("pass_launch", ativo, 1);
    to_tick();
    chk("pass_y", y, 397); chk("pass_acertou", acertou, 0); chk("pass_pontos", pontos, 1);
    to_tick();
    chk("pass_y2", y, 395);

    // pause mid-flight
    pausa = 1'b1;
    for (int i = 0; i < 100; i++) begin
      disparo = ~disparo;
      clk1();
    end
    chk("pause_y", y, 395); chk("pause_x", x, 322);
    chk("pause_acertou", acertou, 0); chk("pause_ativo", ativo, 1);
    pausa = 1'b0; disparo = 1'b0;
    repeat (3 - ph) clk1();
    chk("pause_resume_hold", y, 395);
    clk1();
    chk("pause_resume_move", y, 393);

    restart();
    chk("restart_pontos", pontos, 0); chk("restart_y", y, 1000); chk("restart_ativo", ativo, 0);

    // ship at the very top cannot launch
    y_nave = 10'd0;
    fire();
    chk("ynave0_ativo", ativo, 0); chk("ynave0_y", y, 1000);
    clk1();

    // top exit then cooldown
    y_nave = 10'd5;
    fire();
    chk("top_launch_y", y, 4);
    to_tick(); chk("top_y2", y, 2);
    to_tick(); chk("top_y0", y, 0);
    to_tick();
    chk("top_park_y", y, 1000); chk("top_ativo", ativo, 0); chk("top_acertou", acertou, 0);
    repeat (19) to_tick();
    fire(); clk1();
    chk("cool_ignore", ativo, 0);
    to_tick();
    fire();
    chk("cool_done_ativo", ativo, 1); chk("cool_done_y", y, 4);
    restart();

    // inclusive box corners: x=322=282+40, y=399=367+32
    y_nave = 10'd400; x_inimigo = 10'd282; y_inimigo = 10'd367; inimigo_vivo = 1'b1;
    fire(); to_tick();
    chk("edge_hit", acertou, 1); chk("edge_pontos", pontos, 1);
    restart();
    x_inimigo = 10'd281;
    fire(); to_tick();
    chk("xmiss_acertou", acertou, 0); chk("xmiss_y", y, 397);
    restart();
    x_inimigo = 10'd282; y_inimigo = 10'd366;
    fire(); to_tick();
    chk("ymiss_acertou", acertou, 0); chk("ymiss_y", y, 397);
    restart();

    // restart on the hitting tick wins
    y_inimigo = 10'd380; x_inimigo = 10'd310;
    fire();
    repeat (3 - ph) clk1();
    reiniciarJogo = 1'b1; clk1(); reiniciarJogo = 1'b0;
    chk("rj_override_acertou", acertou, 0); chk("rj_override_pontos", pontos, 0);
    chk("rj_override_y", y, 1000);

    // saturation
    for (int i = 0; i < 256; i++) begin
      fire(); to_tick();
      chk("sat_pontos", pontos, (i + 1 > 255) ? 255 : i + 1);
      repeat (20) to_tick();
    end
    chk("sat_final", pontos, 255);
    restart();
    chk("sat_restart_pontos", pontos, 0); chk("sat_restart_x", x, 1000);
    fire();
    chk("sat_restart_launch", ativo, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
